dcache_direct_mapped: RTL

- Direct-mapped, write-back, write-allocate data cache between the core's load/store port and the ram_cache_glue block-transfer interface.
- Hits complete combinationally in the request cycle, matching the single-cycle core.
- Misses stall the core while the FSM writes back a dirty victim (if needed) and refills a whole BLOCKS-word line over the glue's block interface.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_line_store.sv | 63 ++++++
 rtl/dcache_direct_mapped.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_pkg : shared types and byte-merge helper for the data cache   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dcache_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        LOOKUP    = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    function automatic word_t be_merge(input word_t old_word, input word_t new_word,
                                       input logic [3:0] be);
        word_t result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_line_store : valid/dirty/tag/data arrays, one read port and   |
// | two write ports (cpu word merge, refill line). Rev 1.0               |
// +----------------------------------------------------------------------+
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int BLOCKS = 4,
    parameter int SETS   = 64,
    parameter int TAG_W  = 22
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [$clog2(SETS)-1:0]     index,
    output logic                        rd_valid,
    output logic                        rd_dirty,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [BLOCKS*32-1:0]        rd_line,
    input  logic                        cpu_wr,
    input  logic [$clog2(BLOCKS)-1:0]   cpu_word,
    input  logic [3:0]                  cpu_be,
    input  logic [31:0]                 cpu_wdata,
    input  logic                        fill_wr,
    input  logic [TAG_W-1:0]            fill_tag,
    input  logic [BLOCKS*32-1:0]        fill_line
);

    logic [SETS-1:0]        r_valid;
    logic [SETS-1:0]        r_dirty;
    logic [TAG_W-1:0]       r_tag  [SETS];
    logic [BLOCKS*32-1:0]   r_data [SETS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (fill_wr) begin
            r_valid[index] <= 1'b1;
            r_dirty[index] <= 1'b0;
        end else if (cpu_wr) begin
            r_dirty[index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid gates their use.
    always_ff @(posedge clock) begin
        if (fill_wr) begin
            r_tag[index]  <= fill_tag;
            r_data[index] <= fill_line;
        end else if (cpu_wr) begin
            r_data[index][{cpu_word, 5'b0} +: 32] <=
                be_merge(r_data[index][{cpu_word, 5'b0} +: 32], cpu_wdata, cpu_be);
        end
    end

    assign rd_valid = r_valid[index];
    assign rd_dirty = r_dirty[index];
    assign rd_tag   = r_tag[index];
    assign rd_line  = r_data[index];

endmodule
`default_nettype wire

// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_direct_mapped : direct-mapped write-back write-allocate cache |
// | Optional: DCACHE_PERF_COUNTERS_EN adds hit/miss/writeback counters.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int BLOCKS = 4,
    parameter int SETS   = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_addr,
    input  logic                    cpu_we,
    input  logic [3:0]              cpu_be,
    input  logic [31:0]             cpu_wdata,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_stall,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    output logic                    mem_we,
    output logic [BLOCKS*32-1:0]    mem_write_block,
    input  logic [BLOCKS*32-1:0]    mem_read_block,
    input  logic                    mem_miss
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]             perf_hits,
    output logic [31:0]             perf_misses,
    output logic [31:0]             perf_writebacks
`endif
);

    localparam int c_WSEL_W = $clog2(BLOCKS);
    localparam int c_OFF_W  = 2 + c_WSEL_W;
    localparam int c_IDX_W  = $clog2(SETS);
    localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_TAG_W-1:0]     w_tag;
    logic [c_IDX_W-1:0]     w_index;
    logic [c_WSEL_W-1:0]    w_word;
    logic                   w_hit;
    logic                   w_cpu_wr;
    logic                   w_fill_wr;

    logic                   w_rd_valid;
    logic                   w_rd_dirty;
    logic [c_TAG_W-1:0]     w_rd_tag;
    logic [BLOCKS*32-1:0]   w_rd_line;

    logic                   w_unused_addr;

    assign w_tag         = cpu_addr[31 -: c_TAG_W];
    assign w_index       = cpu_addr[c_OFF_W +: c_IDX_W];
    assign w_word        = cpu_addr[2 +: c_WSEL_W];
    assign w_unused_addr = &{1'b0, cpu_addr[1:0]};
    assign w_hit         = cpu_req && w_rd_valid && (w_rd_tag == w_tag);

    dcache_line_store #(
        .BLOCKS (BLOCKS),
        .SETS   (SETS),
        .TAG_W  (c_TAG_W)
    ) u_line_store (
        .clock      (clock),
        .reset      (reset),
        .index      (w_index),
        .rd_valid   (w_rd_valid),
        .rd_dirty   (w_rd_dirty),
        .rd_tag     (w_rd_tag),
        .rd_line    (w_rd_line),
        .cpu_wr     (w_cpu_wr),
        .cpu_word   (w_word),
        .cpu_be     (cpu_be),
        .cpu_wdata  (cpu_wdata),
        .fill_wr    (w_fill_wr),
        .fill_tag   (w_tag),
        .fill_line  (mem_read_block)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= LOOKUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        cpu_stall       = 1'b0;
        cpu_rdata       = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_write_block = '0;
        w_cpu_wr        = 1'b0;
        w_fill_wr       = 1'b0;
        case (r_state)
            LOOKUP: begin
                if (w_hit) begin
                    w_cpu_wr = cpu_we;
                    if (!cpu_we) begin
                        cpu_rdata = w_rd_line[{w_word, 5'b0} +: 32];
                    end
                end else if (cpu_req) begin
                    cpu_stall    = 1'b1;
                    w_state_next = (w_rd_valid && w_rd_dirty) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                // Dirty stays set: the following refill replaces the whole line.
                cpu_stall       = 1'b1;
                mem_req         = 1'b1;
                mem_we          = 1'b1;
                mem_addr        = {w_rd_tag, w_index, {c_OFF_W{1'b0}}};
                mem_write_block = w_rd_line;
                if (!mem_miss) begin
                    w_state_next = REFILL;
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {w_tag, w_index, {c_OFF_W{1'b0}}};
                if (!mem_miss) begin
                    w_fill_wr    = 1'b1;
                    w_state_next = LOOKUP;
                end
            end
            default: begin
                w_state_next = LOOKUP;
            end
        endcase
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    logic r_replay;

    // The first LOOKUP after a refill replays the missed access; not a hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_replay        <= 1'b0;
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            r_replay <= w_fill_wr;
            if (r_state == LOOKUP && w_hit && !r_replay) begin
                perf_hits <= perf_hits + 32'd1;
            end
            if (r_state == LOOKUP && w_state_next != LOOKUP) begin
                perf_misses <= perf_misses + 32'd1;
            end
            if (r_state == WRITEBACK && !mem_miss) begin
                perf_writebacks <= perf_writebacks + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
